div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide parameter DW, default 16, dividend and quotient width in bits.
REQ-002 SHALL provide parameter SW, default 8, divisor and remainder width in bits; SW <= DW.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port clr  input  1  reset; synchronous, active-high.
REQ-005 SHALL provide port start  input  1  request to begin a division with the current operands.
REQ-006 SHALL provide port dividend  input  DW  unsigned dividend, sampled only on an accepted start.
REQ-007 SHALL provide port divisor  input  SW  unsigned divisor, sampled only on an accepted start.
REQ-008 SHALL provide port busy  output  1  high while an iteration sequence is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse; results are valid.
REQ-010 SHALL provide port quotient  output  DW  unsigned quotient, registered.
REQ-011 SHALL provide port remainder  output  SW  unsigned remainder, registered.
REQ-012 SHALL provide port err  output  1  divide-by-zero flag; present only when DIV_ZERO_CHK_EN is defined.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE: latch operands, clear the partial remainder, load the bit counter with DW, and enter RUN.
REQ-015 SHALL ignore start while in RUN; latched operands are unaffected.
REQ-016 SHALL use a restoring algorithm in RUN, one quotient bit per cycle, MSB first.
REQ-017 Each RUN step SHALL shift R (SW+1 bits) left, insert the next dividend bit, and test R >= divisor. If true, it SHALL subtract the divisor and set the quotient bit to 1; otherwise the quotient bit SHALL be 0.
REQ-018 SHALL hold busy=1 for exactly DW cycles after the accepting edge, then go to DONE with done=1 for exactly one cycle.
REQ-019 SHALL compute results so that dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor.
REQ-020 SHALL hold quotient, remainder and err stable from done until the next accepted start; they SHALL be unchanged during RUN.
REQ-021 SHALL return from DONE to IDLE on the next edge unless start is high, in which case it SHALL go directly to RUN (back-to-back operation).
REQ-022 When start and clr are both high on the same edge, clr SHALL win.

Reset
REQ-023 On clr, SHALL enter IDLE and force busy=0, done=0, quotient=0, remainder=0 and err=0, regardless of state.
REQ-024 clr during RUN SHALL abort the division; done SHALL never pulse for the aborted operation.

Configuration
REQ-025 With DIV_ZERO_CHK_EN defined, a start with divisor==0 SHALL skip RUN. Next edge: enter DONE with err=1, quotient=all ones, remainder=dividend[SW-1:0], busy never high. err SHALL clear on the next accepted start with a nonzero divisor.
REQ-026 Without DIV_ZERO_CHK_EN, the err port SHALL be absent. divisor==0 SHALL run the full DW cycles and naturally yield quotient=all ones and remainder=dividend[SW-1:0].

Structure
REQ-027 SHALL place the state encoding typedef and the default widths DW=16 and SW=8 in shared package div_pkg.
REQ-028 SHALL factor one iteration (shift, compare, conditional subtract, quotient bit) into combinational sub-module div_step.

Verification
REQ-029 Divide 1000 by 7 -> done after 16 busy cycles, quotient=142, remainder=6.
REQ-030 Divide 0xFFFF by 0xFF -> quotient=257, remainder=0. Divide 5 by 10 -> quotient=0, remainder=5.
REQ-031 Back-to-back: start held through DONE with 100/3 then 9/9 -> results 33 r 1 then 1 r 0; no IDLE cycle between them.
REQ-032 start pulsed with new operands mid-RUN -> ignored; original result is delivered unchanged.
REQ-033 clr asserted at RUN cycle 8 -> next edge busy=0, done=0, quotient=0, remainder=0; no done pulse follows.
REQ-034 Divisor 0 with dividend 0x1234 -> quotient=0xFFFF, remainder=0x34. With the macro: err=1 after 1 cycle. Without it: after 16 busy cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared widths, state encoding and observable status for the restoring divider.
// The divide-by-zero check is compiled in only when DIV_ZERO_CHK_EN is defined.
package div_pkg;

   localparam int DW_DEFAULT = 16;
   localparam int SW_DEFAULT = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Status view of the controller; busy/done are decoded from it so the
   // state seen by a checker is exactly the state that drives the outputs.
   typedef struct packed {
      state_t state;
      logic   busy;
      logic   done;
   } div_dbg_t;

   function automatic div_dbg_t make_dbg(state_t s);
      div_dbg_t d;
      d.state = s;
      d.busy  = (s == ST_RUN);
      d.done  = (s == ST_DONE);
      return d;
   endfunction

   function automatic logic is_accepting(state_t s);
      return (s == ST_IDLE) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder, bring in the
// next dividend bit, compare against the divisor and conditionally subtract.
module div_step
   import div_pkg::*;
#(
   parameter int SW = SW_DEFAULT
) (
   input  logic [SW:0]   r_in,
   input  logic          bit_in,
   input  logic [SW-1:0] divisor,
   output logic [SW:0]   r_out,
   output logic          q_bit
);

   logic [SW:0] r_shift;
   logic [SW:0] d_ext;
   logic        unused_msb;

   // The shift drops R's top bit; it can only be set when divisor is zero.
   always_comb begin
      unused_msb = r_in[SW];
      r_shift    = {r_in[SW-1:0], bit_in};
      d_ext      = {1'b0, divisor};
      q_bit      = (r_shift >= d_ext);
      r_out      = q_bit ? (r_shift - d_ext) : r_shift;
   end

endmodule

// File: rtl/div_unit.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Defining DIV_ZERO_CHK_EN adds the err port and a one-cycle divide-by-zero path.
module div_unit
   import div_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int SW = SW_DEFAULT
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [SW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
`ifdef DIV_ZERO_CHK_EN
   output logic [SW-1:0] remainder,
   output logic          err
`else
   output logic [SW-1:0] remainder
`endif
);

   // Handshake: start is a level request sampled on each rising edge; it is
   // accepted only in IDLE or DONE (operands latched on that edge) and ignored
   // in RUN. done is a one-cycle pulse; results hold until the next acceptance.

   localparam int CW = $clog2(DW + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] work_q, work_d;
   logic [SW-1:0] dvs_q, dvs_d;
   logic [SW:0]   r_q, r_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [SW-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_CHK_EN
   logic          err_q, err_d;
`endif

   logic [SW:0]   step_r;
   logic          step_q_bit;
   logic          accept;
   logic          load_run;
   div_dbg_t      dbg;

   assign dbg = make_dbg(state_q);

   div_step #(
      .SW(SW)
   ) u_step (
      .r_in   (r_q),
      .bit_in (work_q[DW-1]),
      .divisor(dvs_q),
      .r_out  (step_r),
      .q_bit  (step_q_bit)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      dvs_d    = dvs_q;
      r_d      = r_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
`ifdef DIV_ZERO_CHK_EN
      err_d    = err_q;
`endif
      accept   = start && is_accepting(dbg.state);
      load_run = accept;

      case (dbg.state)
         ST_RUN: begin
            // work_q doubles as dividend feed (MSB out) and quotient collector (LSB in).
            r_d    = step_r;
            work_d = {work_q[DW-2:0], step_q_bit};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_DONE;
               quot_d  = {work_q[DW-2:0], step_q_bit};
               rem_d   = step_r[SW-1:0];
            end
         end
         default: begin
`ifdef DIV_ZERO_CHK_EN
            if (accept && (divisor == '0)) begin
               load_run = 1'b0;
               state_d  = ST_DONE;
               quot_d   = '1;
               rem_d    = dividend[SW-1:0];
               err_d    = 1'b1;
            end else if (accept) begin
               err_d    = 1'b0;
            end
`endif
            if (load_run) begin
               state_d = ST_RUN;
               work_d  = dividend;
               dvs_d   = divisor;
               r_d     = '0;
               cnt_d   = CW'(DW);
            end else if (!accept) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
`ifdef DIV_ZERO_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
`ifdef DIV_ZERO_CHK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign busy      = dbg.busy;
   assign done      = dbg.done;
   assign quotient  = quot_q;
   assign remainder = rem_q;
`ifdef DIV_ZERO_CHK_EN
   assign err       = err_q;
`endif

endmodule
